// File: rtl/mux_v_n_code_out.sv
// Frame reader: fetches packed words from BRAM and streams them MSB-first as SYM_W-bit symbols.
// Define MUX_VSK_PAD_EN to skip the top 2 VSK padding bits of every word.
module mux_v_n_code_out #(
   parameter int DATA_W      = 32,
   parameter int SYM_W       = 2,
   parameter int ADDR_W      = 10,
   parameter int LENGHT_BRAM = 1024,
   parameter int RD_LAT      = 1
) (
   input  logic              clk_120,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   frame_len,
   input  logic              locked_rd,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   output logic [SYM_W-1:0]  sym_out,
   output logic              sym_valid,
   input  logic              sym_ready,
   output logic              sym_first,
   output logic              sym_last,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

`ifdef MUX_VSK_PAD_EN
   localparam int ACT_W = DATA_W - 2;
`else
   localparam int ACT_W = DATA_W;
`endif
   localparam int SPW   = ACT_W / SYM_W;
   localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;
   localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SPW - 1);
   localparam logic [ADDR_W:0]  LEN_MAX  = (ADDR_W+1)'(LENGHT_BRAM);
   localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [ADDR_W:0]    word_idx_q, word_idx_d;
   logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic [DATA_W-1:0]  sh_q, sh_d;
   logic               sh_valid_q, sh_valid_d;
   logic [DATA_W-1:0]  pf_data_q, pf_data_d;
   logic               pf_full_q, pf_full_d;
   logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
   logic               bram_en_q, bram_en_d;
   logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
   logic               aborted_q, aborted_d;

   logic               data_valid;
   logic               xfer;
   logic               is_last_sym;
   logic               is_last;
   logic [ADDR_W:0]    len_clamped;
   logic               load_word;
   logic [DATA_W-1:0]  load_data;
   logic [ADDR_W:0]    new_idx;

   assign data_valid  = rd_pipe_q[RD_LAT-1];
   assign xfer        = sym_valid && sym_ready;
   assign is_last_sym = (sym_cnt_q == LAST_SYM);
   assign is_last     = is_last_sym && (word_idx_q == len_q - ONE);
   assign len_clamped = (frame_len > LEN_MAX) ? LEN_MAX : frame_len;

   always_ff @(posedge clk_120) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         word_idx_q  <= '0;
         sym_cnt_q   <= '0;
         sh_q        <= '0;
         sh_valid_q  <= 1'b0;
         pf_data_q   <= '0;
         pf_full_q   <= 1'b0;
         rd_pipe_q   <= '0;
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         sym_cnt_q   <= sym_cnt_d;
         sh_q        <= sh_d;
         sh_valid_q  <= sh_valid_d;
         pf_data_q   <= pf_data_d;
         pf_full_q   <= pf_full_d;
         rd_pipe_q   <= rd_pipe_d;
         bram_en_q   <= bram_en_d;
         bram_addr_q <= bram_addr_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      sym_cnt_d   = sym_cnt_q;
      sh_d        = sh_q;
      sh_valid_d  = sh_valid_q;
      pf_data_d   = pf_data_q;
      pf_full_d   = pf_full_q;
      rd_pipe_d   = RD_LAT'({rd_pipe_q, bram_en_q});
      bram_en_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      aborted_d   = 1'b0;
      load_word   = 1'b0;
      load_data   = bram_dout;
      new_idx     = word_idx_q;

      case (state_q)
         IDLE: begin
            if (start && !locked_rd) begin
               len_d      = len_clamped;
               word_idx_d = '0;
               sym_cnt_d  = '0;
               if (len_clamped == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d     = FETCH;
                  bram_en_d   = 1'b1;
                  bram_addr_d = '0;
               end
            end
         end
         FETCH: begin
            if (data_valid) begin
               load_word = 1'b1;
               state_d   = STREAM;
            end
         end
         STREAM: begin
            // Only one read is ever in flight, so an arriving word never collides with a full buffer.
            if (data_valid) begin
               pf_data_d = bram_dout;
               pf_full_d = 1'b1;
            end
            if (xfer) begin
               if (is_last) begin
                  state_d    = FINISH;
                  sh_valid_d = 1'b0;
               end else if (is_last_sym) begin
                  word_idx_d = word_idx_q + ONE;
                  sym_cnt_d  = '0;
                  new_idx    = word_idx_q + ONE;
                  if (pf_full_q) begin
                     load_word = 1'b1;
                     load_data = pf_data_q;
                  end else if (data_valid) begin
                     load_word = 1'b1;
                  end else begin
                     sh_valid_d = 1'b0;
                  end
               end else begin
                  sh_d      = sh_q << SYM_W;
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end
            end else if (!sh_valid_q) begin
               if (pf_full_q) begin
                  load_word = 1'b1;
                  load_data = pf_data_q;
               end else if (data_valid) begin
                  load_word = 1'b1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A word entering the shift register triggers the prefetch of the following one.
      if (load_word) begin
         sh_d       = load_data;
         sh_valid_d = 1'b1;
         pf_full_d  = 1'b0;
         if ((new_idx + ONE) < len_q) begin
            bram_en_d   = 1'b1;
            bram_addr_d = ADDR_W'(new_idx + ONE);
         end
      end

      if ((state_q != IDLE) && locked_rd) begin
         state_d     = IDLE;
         len_d       = '0;
         word_idx_d  = '0;
         sym_cnt_d   = '0;
         sh_d        = '0;
         sh_valid_d  = 1'b0;
         pf_data_d   = '0;
         pf_full_d   = 1'b0;
         rd_pipe_d   = '0;
         bram_en_d   = 1'b0;
         bram_addr_d = '0;
         aborted_d   = 1'b1;
      end
   end

   always_comb begin
      sym_valid = (state_q == STREAM) && sh_valid_q;
      sym_out   = sh_q[ACT_W-1 -: SYM_W];
      sym_first = sym_valid && (sym_cnt_q == '0) && (word_idx_q == '0);
      sym_last  = sym_valid && is_last;
      busy      = (state_q == FETCH) || (state_q == STREAM);
      done      = (state_q == FINISH) && !locked_rd;
      aborted   = aborted_q;
      bram_en   = bram_en_q;
      bram_addr = bram_addr_q;
   end

endmodule

// File: tb/tb_mux_v_n_code_out.sv
// Directed bench for mux_v_n_code_out with a 1-cycle-latency BRAM model.
// Honours MUX_VSK_PAD_EN in its expected symbol model.
module tb_mux_v_n_code_out;

`ifdef MUX_VSK_PAD_EN
   localparam int TB_ACT_W = 30;
   localparam int TB_SPW   = 15;
   localparam int TB_SKEW  = 1;
`else
   localparam int TB_ACT_W = 32;
   localparam int TB_SPW   = 16;
   localparam int TB_SKEW  = 0;
`endif

   logic        clk_120 = 1'b0;
   logic        rst, start, locked_rd, sym_ready;
   logic [10:0] frame_len;
   logic        bram_en;
   logic [9:0]  bram_addr;
   logic [31:0] bram_dout;
   logic [1:0]  sym_out;
   logic        sym_valid, sym_first, sym_last, busy, done, aborted;

   logic [31:0] mem [0:1023];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int start_cyc, valid_first_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
   int done_cnt, abort_cnt;
   bit [1:0] sym_log[$];
   bit       first_log[$];
   bit       last_log[$];
   int       addr_log[$];

   mux_v_n_code_out dut (
      .clk_120(clk_120), .rst(rst), .start(start), .frame_len(frame_len),
      .locked_rd(locked_rd), .bram_en(bram_en), .bram_addr(bram_addr),
      .bram_dout(bram_dout), .sym_out(sym_out), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .sym_first(sym_first), .sym_last(sym_last),
      .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk_120 = ~clk_120;

   always @(posedge clk_120) begin
      cyc <= cyc + 1;
      if (bram_en) bram_dout <= mem[bram_addr];
   end

   always @(negedge clk_120) begin
      if (sym_valid && sym_ready) begin
         sym_log.push_back(sym_out);
         first_log.push_back(sym_first);
         last_log.push_back(sym_last);
         if (sym_log.size() == 1) first_xfer_cyc = cyc;
         last_xfer_cyc = cyc;
      end
      if (sym_valid && valid_first_cyc < 0) valid_first_cyc = cyc;
      if (bram_en) addr_log.push_back(int'(bram_addr));
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (aborted) abort_cnt++;
   end

   function automatic bit [1:0] exp_sym(input int w, input int s);
      logic [31:0] word;
      word = mem[w];
      return word[TB_ACT_W-1-2*s -: 2];
   endfunction

   task automatic tick();
      @(posedge clk_120);
      #1;
   endtask

   task automatic clear_logs();
      sym_log.delete();
      first_log.delete();
      last_log.delete();
      addr_log.delete();
      valid_first_cyc = -1;
      first_xfer_cyc  = -1;
      last_xfer_cyc   = -1;
      done_cyc        = -1;
      done_cnt        = 0;
      abort_cnt       = 0;
   endtask

   task automatic pulse_start(input int len);
      frame_len = 11'(len);
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_until_done(input int budget, output bit timed_out);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
      timed_out = (done_cnt == 0);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; frame_len = 11'd1; locked_rd = 1'b0; sym_ready = 1'b1;
      tick(); tick(); tick();
      nvec++; if ({sym_valid, busy, done, aborted, bram_en, sym_first, sym_last} !== 7'b0) begin
         nerr++; $display("[TB] FAIL reset_flags: got %b want 0000000", {sym_valid, busy, done, aborted, bram_en, sym_first, sym_last});
      end
      nvec++; if (bram_addr !== 10'd0) begin nerr++; $display("[TB] FAIL reset_addr: got %0d want 0", bram_addr); end
      nvec++; if (sym_out !== 2'd0) begin nerr++; $display("[TB] FAIL reset_sym_out: got %0d want 0", sym_out); end
      start = 1'b0; rst = 1'b0;
      tick(); tick();
      nvec++; if (busy !== 1'b0) begin nerr++; $display("[TB] FAIL reset_start_dropped: got busy %0b want 0", busy); end
   endtask

   task automatic test_single_word();
      bit to;
      int bad, nf, nl;
      mem[0] = 32'hE4E4_E4E4;
      clear_logs();
      pulse_start(1);
      nvec++; if ({bram_en, busy, sym_valid} !== 3'b110 || bram_addr !== 10'd0) begin
         nerr++; $display("[TB] FAIL single_fetch_entry: got en/busy/valid %b addr %0d want 110 addr 0", {bram_en, busy, sym_valid}, bram_addr);
      end
      run_until_done(200, to);
      nvec++; if (to) begin nerr++; $display("[TB] FAIL single_timeout: got no done want done"); end
      nvec++; if (valid_first_cyc - start_cyc !== 3) begin nerr++; $display("[TB] FAIL single_latency: got %0d want 3", valid_first_cyc - start_cyc); end
      nvec++; if (sym_log.size() !== TB_SPW) begin nerr++; $display("[TB] FAIL single_count: got %0d want %0d", sym_log.size(), TB_SPW); end
      bad = 0; nf = 0; nl = 0;
      foreach (sym_log[k]) begin
         if (int'(sym_log[k]) !== 3 - ((k + TB_SKEW) % 4)) bad++;
         nf += int'(first_log[k]);
         nl += int'(last_log[k]);
      end
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL single_symbols: got %0d wrong want 0", bad); end
      nvec++; if (nf !== 1 || first_log[0] !== 1'b1) begin nerr++; $display("[TB] FAIL single_first: got %0d flags want 1 on symbol 0", nf); end
      nvec++; if (nl !== 1 || last_log[TB_SPW-1] !== 1'b1) begin nerr++; $display("[TB] FAIL single_last: got %0d flags want 1 on final symbol", nl); end
      nvec++; if (done_cyc !== last_xfer_cyc + 1) begin nerr++; $display("[TB] FAIL single_done_timing: got %0d want %0d", done_cyc, last_xfer_cyc + 1); end
      nvec++; if (addr_log.size() !== 1 || busy !== 1'b0) begin nerr++; $display("[TB] FAIL single_reads: got %0d reads busy %0b want 1 reads busy 0", addr_log.size(), busy); end
   endtask

   task automatic test_back_to_back();
      bit to;
      int bad;
      mem[0] = 32'h0123_4567; mem[1] = 32'h89AB_CDEF; mem[2] = 32'hFEDC_BA98; mem[3] = 32'h7654_3210;
      clear_logs();
      pulse_start(4);
      run_until_done(300, to);
      nvec++; if (to) begin nerr++; $display("[TB] FAIL b2b_timeout: got no done want done"); end
      nvec++; if (sym_log.size() !== 4*TB_SPW) begin nerr++; $display("[TB] FAIL b2b_count: got %0d want %0d", sym_log.size(), 4*TB_SPW); end
      bad = 0;
      foreach (sym_log[k]) if (sym_log[k] !== exp_sym(k / TB_SPW, k % TB_SPW)) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL b2b_symbols: got %0d wrong want 0", bad); end
      nvec++; if (last_xfer_cyc - first_xfer_cyc !== 4*TB_SPW - 1) begin
         nerr++; $display("[TB] FAIL b2b_no_gaps: got span %0d want %0d", last_xfer_cyc - first_xfer_cyc, 4*TB_SPW - 1);
      end
      nvec++; if (addr_log.size() !== 4) begin nerr++; $display("[TB] FAIL b2b_en_pulses: got %0d want 4", addr_log.size()); end
      bad = 0;
      foreach (addr_log[k]) if (addr_log[k] !== k) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL b2b_addr_seq: got %0d wrong addresses want 0", bad); end
   endtask

   task automatic test_backpressure();
      bit pat [3] = '{1'b1, 1'b0, 1'b0};
      bit prev_stall;
      logic [1:0] prev_out;
      logic prev_first, prev_last;
      int bad;
      mem[0] = 32'h1B6C_93E4; mem[1] = 32'hD2A5_0F78;
      clear_logs();
      pulse_start(2);
      prev_stall = 1'b0; prev_out = '0; prev_first = 1'b0; prev_last = 1'b0;
      for (int t = 0; t < 500 && done_cnt == 0; t++) begin
         if (prev_stall) begin
            nvec++;
            if (sym_valid !== 1'b1 || sym_out !== prev_out || sym_first !== prev_first || sym_last !== prev_last) begin
               nerr++; $display("[TB] FAIL bp_stable: got v%0b sym %0d f%0b l%0b want v1 sym %0d f%0b l%0b",
                                sym_valid, sym_out, sym_first, sym_last, prev_out, prev_first, prev_last);
            end
         end
         sym_ready  = pat[t % 3];
         prev_stall = sym_valid && !sym_ready;
         prev_out   = sym_out;
         prev_first = sym_first;
         prev_last  = sym_last;
         tick();
      end
      sym_ready = 1'b1;
      tick();
      nvec++; if (done_cnt !== 1) begin nerr++; $display("[TB] FAIL bp_done: got %0d want 1", done_cnt); end
      nvec++; if (sym_log.size() !== 2*TB_SPW) begin nerr++; $display("[TB] FAIL bp_count: got %0d want %0d", sym_log.size(), 2*TB_SPW); end
      bad = 0;
      foreach (sym_log[k]) if (sym_log[k] !== exp_sym(k / TB_SPW, k % TB_SPW)) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL bp_order: got %0d wrong want 0", bad); end
   endtask

   task automatic test_abort();
      bit to;
      mem[0] = 32'hE4E4_E4E4;
      clear_logs();
      pulse_start(8);
      for (int t = 0; t < 200 && !(sym_log.size() == 20 && sym_valid); t++) tick();
      nvec++; if (sym_log.size() !== 20) begin nerr++; $display("[TB] FAIL abort_reach: got %0d transfers want 20", sym_log.size()); end
      locked_rd = 1'b1;
      tick();
      nvec++; if ({sym_valid, aborted, busy, bram_en} !== 4'b0100) begin
         nerr++; $display("[TB] FAIL abort_next: got v/ab/busy/en %b want 0100", {sym_valid, aborted, busy, bram_en});
      end
      locked_rd = 1'b0;
      tick(); tick(); tick();
      nvec++; if (done_cnt !== 0 || abort_cnt !== 1 || aborted !== 1'b0) begin
         nerr++; $display("[TB] FAIL abort_pulses: got done %0d aborted %0d want done 0 aborted 1", done_cnt, abort_cnt);
      end
      clear_logs();
      pulse_start(1);
      run_until_done(200, to);
      nvec++; if (to || addr_log.size() !== 1 || addr_log[0] !== 0 || sym_log.size() !== TB_SPW) begin
         nerr++; $display("[TB] FAIL abort_restart: got reads %0d symbols %0d want reads 1 at 0 symbols %0d", addr_log.size(), sym_log.size(), TB_SPW);
      end
   endtask

   task automatic test_locked_start_and_reset();
      clear_logs();
      locked_rd = 1'b1;
      pulse_start(2);
      tick(); tick();
      nvec++; if (busy !== 1'b0 || addr_log.size() !== 0 || abort_cnt !== 0) begin
         nerr++; $display("[TB] FAIL locked_start: got busy %0b reads %0d aborts %0d want 0 0 0", busy, addr_log.size(), abort_cnt);
      end
      locked_rd = 1'b0;
      clear_logs();
      pulse_start(2);
      for (int t = 0; t < 10; t++) tick();
      rst = 1'b1;
      tick();
      nvec++; if ({sym_valid, busy, aborted, bram_en} !== 4'b0000) begin
         nerr++; $display("[TB] FAIL reset_midframe: got v/busy/ab/en %b want 0000", {sym_valid, busy, aborted, bram_en});
      end
      rst = 1'b0;
      tick(); tick();
      nvec++; if (abort_cnt !== 0 || done_cnt !== 0) begin
         nerr++; $display("[TB] FAIL reset_midframe_pulses: got aborted %0d done %0d want 0 0", abort_cnt, done_cnt);
      end
   endtask

   task automatic test_boundaries();
      bit to;
      int bad, nl;
      clear_logs();
      pulse_start(0);
      tick(); tick(); tick();
      nvec++; if (done_cnt !== 1 || valid_first_cyc !== -1 || addr_log.size() !== 0) begin
         nerr++; $display("[TB] FAIL len0: got done %0d valid_cyc %0d reads %0d want 1 -1 0", done_cnt, valid_first_cyc, addr_log.size());
      end
      for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
      clear_logs();
      pulse_start(2000);
      for (int t = 0; t < 50; t++) tick();
      frame_len = 11'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_until_done(20000, to);
      nvec++; if (to || done_cnt !== 1) begin nerr++; $display("[TB] FAIL clamp_done: got %0d want 1", done_cnt); end
      nvec++; if (sym_log.size() !== 1024*TB_SPW) begin nerr++; $display("[TB] FAIL clamp_count: got %0d want %0d", sym_log.size(), 1024*TB_SPW); end
      nvec++; if (addr_log.size() !== 1024 || addr_log[0] !== 0 || addr_log[addr_log.size()-1] !== 1023) begin
         nerr++; $display("[TB] FAIL clamp_addr: got %0d reads ending at %0d want 1024 ending at 1023", addr_log.size(), addr_log[addr_log.size()-1]);
      end
      bad = 0; nl = 0;
      foreach (sym_log[k]) begin
         if (sym_log[k] !== exp_sym(k / TB_SPW, k % TB_SPW)) bad++;
         nl += int'(last_log[k]);
      end
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL clamp_symbols: got %0d wrong want 0", bad); end
      nvec++; if (nl !== 1 || last_log[1024*TB_SPW-1] !== 1'b1) begin
         nerr++; $display("[TB] FAIL clamp_last: got %0d last flags want 1 on symbol %0d", nl, 1024*TB_SPW-1);
      end
   endtask

`ifdef MUX_VSK_PAD_EN
   task automatic test_pad();
      bit to;
      int bad;
      mem[0] = 32'hFFFF_FFFE;
      clear_logs();
      pulse_start(1);
      run_until_done(200, to);
      nvec++; if (to || sym_log.size() !== 15) begin nerr++; $display("[TB] FAIL pad_count: got %0d want 15", sym_log.size()); end
      bad = 0;
      foreach (sym_log[k]) if (int'(sym_log[k]) !== ((k < 14) ? 3 : 2)) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("[TB] FAIL pad_symbols: got %0d wrong want 0", bad); end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; locked_rd = 1'b0; sym_ready = 1'b1; frame_len = '0;
      clear_logs();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_locked_start_and_reset();
      test_boundaries();
`ifdef MUX_VSK_PAD_EN
      test_pad();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
